// File: rtl/uart_rx_fifo_if.sv
// Register-block side of the UART receiver.
// Frame format, FIFO read port and status flags.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          rx_tick;
    logic          rx_en_i;
    logic [1:0]    data_bit_num_i;
    logic          parity_en_i;
    logic          parity_type_i;
    logic          stop_bit_num_i;
    logic          rd_en_i;
    logic          clr_ovr_i;
    logic [7:0]    rx_data_o;
    logic [1:0]    rx_err_o;
    logic          rx_valid_o;
    logic [CW-1:0] fifo_count_o;
    logic          rx_done_o;
    logic          overrun_o;

    modport master (
        output rx_tick, rx_en_i, data_bit_num_i, parity_en_i,
        output parity_type_i, stop_bit_num_i, rd_en_i, clr_ovr_i,
        input  rx_data_o, rx_err_o, rx_valid_o, fifo_count_o,
        input  rx_done_o, overrun_o
    );

    modport slave (
        input  rx_tick, rx_en_i, data_bit_num_i, parity_en_i,
        input  parity_type_i, stop_bit_num_i, rd_en_i, clr_ovr_i,
        output rx_data_o, rx_err_o, rx_valid_o, fifo_count_o,
        output rx_done_o, overrun_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with configurable frame format,
// first-word fall-through receive FIFO and RTS flow control.
module uart_rx_fifo #(
    parameter int OVERSAMPLE    = 16,
    parameter int FIFO_DEPTH    = 16,
    parameter int RTS_THRESHOLD = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_fifo_if.slave bus,
    input  logic          rx,
    output logic          rts_n
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] RTS_C     = CW'(RTS_THRESHOLD);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic          rx_s1, rx_s2, rx_d;
    logic          rx_fall, start_frame;
    logic [TW-1:0] tick_cnt;
    logic          half_hit, full_hit, tick_wrap;
    logic [1:0]    nbits_q;
    logic          par_en_q, par_type_q, stop2_q;
    logic [2:0]    bit_cnt;
    logic          last_bit, stop_cnt;
    logic [7:0]    shreg;
    logic          perr_q, ferr_q, ferr_n;
    logic          push_req;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [9:0]    head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full, pop, do_push;
    logic          done_q, ovr_q;

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_fall     = rx_d & ~rx_s2;
    assign start_frame = (state == IDLE) && bus.rx_en_i && rx_fall;
    assign half_hit    = bus.rx_tick && (tick_cnt == HALF_LAST);
    assign full_hit    = bus.rx_tick && (tick_cnt == FULL_LAST);
    assign tick_wrap   = (state == START) ? half_hit : full_hit;
    assign last_bit    = (bit_cnt == (3'd4 + {1'b0, nbits_q}));
    assign ferr_n      = ferr_q | ~rx_s2;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state; a push is requested on the last mid-stop sample.
    always_comb begin
        state_n  = state;
        push_req = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_frame) state_n = START;
            end
            START: begin
                if (!bus.rx_en_i) state_n = IDLE;
                else if (half_hit) state_n = rx_s2 ? IDLE : DATA;
            end
            DATA: begin
                if (!bus.rx_en_i) state_n = IDLE;
                else if (full_hit && last_bit)
                    state_n = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (!bus.rx_en_i) state_n = IDLE;
                else if (full_hit) state_n = STOP;
            end
            STOP: begin
                if (!bus.rx_en_i) state_n = IDLE;
                else if (full_hit && (stop_cnt == stop2_q)) begin
                    state_n  = IDLE;
                    push_req = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Frame datapath: format latch, tick/bit counters, samples, flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt   <= '0;
            nbits_q    <= 2'b11;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            stop2_q    <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else if (start_frame) begin
            tick_cnt   <= '0;
            nbits_q    <= bus.data_bit_num_i;
            par_en_q   <= bus.parity_en_i;
            par_type_q <= bus.parity_type_i;
            stop2_q    <= bus.stop_bit_num_i;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else if (state != IDLE && bus.rx_tick) begin
            tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
            if (full_hit && state == DATA) begin
                shreg[bit_cnt] <= rx_s2;
                bit_cnt        <= bit_cnt + 3'd1;
            end
            if (full_hit && state == PARITY)
                perr_q <= ^shreg ^ rx_s2 ^ par_type_q;
            if (full_hit && state == STOP) begin
                ferr_q   <= ferr_n;
                stop_cnt <= 1'b1;
            end
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign pop     = bus.rd_en_i && !empty;
    assign do_push = push_req && (!full || pop);

    // Storage array; reads are gated by non-empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {ferr_n, perr_q, shreg};
    end

    // FIFO pointers and fill level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Status: done pulse, sticky overrun (set beats clear), RTS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
            rts_n  <= 1'b1;
        end else begin
            done_q <= push_req;
            if (push_req && !do_push) ovr_q <= 1'b1;
            else if (bus.clr_ovr_i)   ovr_q <= 1'b0;
            rts_n <= (count >= RTS_C);
        end
    end

    assign head             = mem[rd_ptr];
    assign bus.rx_data_o    = empty ? 8'h00 : head[7:0];
    assign bus.rx_err_o     = empty ? 2'b00 : head[9:8];
    assign bus.rx_valid_o   = !empty;
    assign bus.fifo_count_o = count;
    assign bus.rx_done_o    = done_q;
    assign bus.overrun_o    = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomised UART frames checked against a
// queue-based model of the receive FIFO.
module tb_uart_rx_fifo;
    localparam int OS     = 16;
    localparam int DEPTH  = 4;
    localparam int RTS_TH = 3;
    localparam int BIT    = 2 * OS;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic rts_n;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .OVERSAMPLE   (OS),
        .FIFO_DEPTH   (DEPTH),
        .RTS_THRESHOLD(RTS_TH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .rx   (rx),
        .rts_n(rts_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int last_done_cyc = 0;
    int t_start = -1;
    int lat = 0;
    int cnt3_cyc = -1;
    int rts1_cyc = -1;
    bit arm = 1'b0;
    logic ovr_exp = 1'b0;
    logic [9:0] mq[$];
    logic [9:0] ent;

    always @(posedge clk) cyc <= cyc + 1;

    // Oversample tick on every even cycle.
    initial begin
        bus.rx_tick = 1'b0;
        forever begin
            @(negedge clk);
            bus.rx_tick = (cyc % 2 == 0);
        end
    end

    // Observe done pulses and RTS/count timing.
    always @(negedge clk) begin
        if (bus.rx_done_o) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (arm && cnt3_cyc < 0 && bus.fifo_count_o == 3) cnt3_cyc = cyc;
        if (arm && rts1_cyc < 0 && rts_n) rts1_cyc = cyc;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fmt(input logic [1:0] nb, input logic pen,
                           input logic pt, input logic s2);
        bus.data_bit_num_i = nb;
        bus.parity_en_i    = pen;
        bus.parity_type_i  = pt;
        bus.stop_bit_num_i = s2;
    endtask

    task automatic align();
        do @(negedge clk); while (cyc % 2 != 0);
    endtask

    // Drives one frame and returns the entry the receiver must store.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] nb,
                              input logic pen, input logic pt,
                              input logic s2, input logic pflip,
                              input logic [1:0] sbad,
                              output logic [9:0] e);
        int n;
        logic [7:0] dm;
        logic pbit;
        n = 5 + int'(nb);
        dm = d & 8'((1 << n) - 1);
        pbit = ^dm ^ pt ^ pflip;
        align();
        rx = 1'b0;
        t_start = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            rx = dm[i];
            repeat (BIT) @(negedge clk);
        end
        if (pen) begin
            rx = pbit;
            repeat (BIT) @(negedge clk);
        end
        rx = ~sbad[0];
        repeat (BIT) @(negedge clk);
        if (s2) begin
            rx = ~sbad[1];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        e = {sbad[0] | (s2 & sbad[1]), pen & (^dm ^ pbit ^ pt), dm};
        exp_done++;
    endtask

    task automatic model_push(input logic [9:0] e);
        if (mq.size() < DEPTH) mq.push_back(e);
        else ovr_exp = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] e;
        chk({tag, "_valid"}, 32'(bus.rx_valid_o), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            e = mq.pop_front();
            chk({tag, "_data"}, 32'(bus.rx_data_o), 32'(e[7:0]));
            chk({tag, "_err"}, 32'(bus.rx_err_o), 32'(e[9:8]));
            bus.rd_en_i = 1'b1;
            @(negedge clk);
            bus.rd_en_i = 1'b0;
            chk({tag, "_cnt"}, 32'(bus.fifo_count_o), 32'(mq.size()));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(bus.rx_valid_o), 0);
        chk({tag, "_cnt"}, 32'(bus.fifo_count_o), 0);
        chk({tag, "_data"}, 32'(bus.rx_data_o), 0);
        chk({tag, "_err"}, 32'(bus.rx_err_o), 0);
        chk({tag, "_done"}, 32'(bus.rx_done_o), 0);
        chk({tag, "_ovr"}, 32'(bus.overrun_o), 0);
        chk({tag, "_rts"}, 32'(rts_n), 1);
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] nb, sb;
        logic pen, pt, s2, pf;
        int k, nf;

        rst_n = 1'b0;
        rx = 1'b1;
        bus.rx_en_i = 1'b1;
        bus.rd_en_i = 1'b0;
        bus.clr_ovr_i = 1'b0;
        set_fmt(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        #1;
        chk("rts_hold", 32'(rts_n), 1);
        @(negedge clk);
        chk("rts_fall", 32'(rts_n), 0);

        // 8N1 0xA5
        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, ent);
        model_push(ent);
        chk("a5_done", 32'(done_cnt), 32'(exp_done));
        chk("a5_data", 32'(bus.rx_data_o), 32'h A5);
        chk("a5_err", 32'(bus.rx_err_o), 0);
        chk("a5_cnt", 32'(bus.fifo_count_o), 1);
        pop_check("a5");
        chk("a5_empty", 32'(bus.rx_valid_o), 0);

        // 7E2: bad parity, then bad second stop bit
        set_fmt(2'b10, 1'b1, 1'b0, 1'b1);
        send_frame(8'h35, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, ent);
        model_push(ent);
        send_frame(8'h4C, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, ent);
        model_push(ent);
        chk("7e2_done", 32'(done_cnt), 32'(exp_done));
        chk("7e2_cnt", 32'(bus.fifo_count_o), 2);
        chk("7e2_data", 32'(bus.rx_data_o), 32'h35);
        chk("7e2_perr", 32'(bus.rx_err_o), 1);
        chk("7e2_msb", 32'(bus.rx_data_o[7]), 0);
        pop_check("7e2_a");
        chk("7e2_ferr", 32'(bus.rx_err_o), 2);
        pop_check("7e2_b");

        // 5-tick low glitch is a false start
        set_fmt(2'b11, 1'b0, 1'b0, 1'b0);
        align();
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("glitch_done", 32'(done_cnt), 32'(exp_done));
        chk("glitch_cnt", 32'(bus.fifo_count_o), 0);
        d = 8'($urandom);
        send_frame(d, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, ent);
        model_push(ent);
        pop_check("post_glitch");

        // Five frames into a 4-deep FIFO
        arm = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            send_frame(d, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, ent);
            model_push(ent);
            if (i == 3) lat = last_done_cyc - t_start;
        end
        arm = 1'b0;
        chk("fill_done", 32'(done_cnt), 32'(exp_done));
        chk("fill_cnt", 32'(bus.fifo_count_o), DEPTH);
        chk("fill_ovr", 32'(bus.overrun_o), 32'(ovr_exp));
        chk("fill_rts", 32'(rts_n), 1);
        chk("rts_lag", 32'(rts1_cyc - cnt3_cyc), 1);
        chk("fill_head", 32'(bus.rx_data_o), 32'(mq[0][7:0]));
        repeat (5) @(negedge clk);
        chk("ovr_sticky", 32'(bus.overrun_o), 1);
        bus.clr_ovr_i = 1'b1;
        @(negedge clk);
        bus.clr_ovr_i = 1'b0;
        ovr_exp = 1'b0;
        chk("ovr_clr", 32'(bus.overrun_o), 32'(ovr_exp));

        // Full FIFO, pop in the push cycle
        t_start = -1;
        d = 8'($urandom);
        fork
            begin
                send_frame(d, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, ent);
            end
            begin
                k = 0;
                while (!(t_start >= 0 && cyc == t_start + lat - 1)
                       && k < 5000) begin
                    @(negedge clk);
                    k++;
                end
                chk("pp_sync", 32'(k < 5000), 1);
                bus.rd_en_i = 1'b1;
                @(negedge clk);
                bus.rd_en_i = 1'b0;
            end
        join
        void'(mq.pop_front());
        model_push(ent);
        chk("pp_done", 32'(done_cnt), 32'(exp_done));
        chk("pp_cnt", 32'(bus.fifo_count_o), DEPTH);
        chk("pp_ovr", 32'(bus.overrun_o), 32'(ovr_exp));
        for (int i = 0; i < DEPTH; i++) pop_check("pp_order");
        chk("pp_empty", 32'(bus.rx_valid_o), 0);
        @(negedge clk);
        chk("pp_rts", 32'(rts_n), 0);

        // Reset in the middle of DATA with a stored entry
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, ent);
        model_push(ent);
        align();
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'(i % 2);
            repeat (BIT) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk_reset("mid");
        mq.delete();
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("mid_hold");
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, ent);
        model_push(ent);
        chk("rst_done", 32'(done_cnt), 32'(exp_done));
        chk("rst_cnt", 32'(bus.fifo_count_o), 1);
        chk("rst_data", 32'(bus.rx_data_o), 32'h5A);
        pop_check("rst");

        // Random formats, data and error injection
        for (int it = 0; it < 8; it++) begin
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                d   = 8'($urandom);
                nb  = 2'($urandom);
                pen = 1'($urandom);
                pt  = 1'($urandom);
                s2  = 1'($urandom);
                pf  = pen & 1'($urandom);
                sb  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
                set_fmt(nb, pen, pt, s2);
                send_frame(d, nb, pen, pt, s2, pf, sb, ent);
                model_push(ent);
            end
            chk("rnd_done", 32'(done_cnt), 32'(exp_done));
            chk("rnd_cnt", 32'(bus.fifo_count_o), 32'(mq.size()));
            while (mq.size() != 0) pop_check("rnd");
        end
        chk("end_ovr", 32'(bus.overrun_o), 32'(ovr_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
